// File: rtl/cpu_trace_extractor.sv
// Purpose : parses the ASCII trace stream into shadow fields and commits them
//           as one decoded record whenever cpu_checker flags a complete line.
// Latency : '#' sampled at edge k, format_type seen at edge k+1, record and
//           valid pulse visible after edge k+1. No backpressure: one char per
//           clk is always consumed, and records are never stalled.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   char         ASCII trace character (same stream cpu_checker sees)
//   format_type  cpu_checker verdict: 00 none, 01 register write, 10 memory write
//   valid        one-cycle pulse when a record is committed
//   kind         record type copied from format_type
//   time_val     decimal time field, binary
//   pc           hex PC field
//   dest         register number (kind 01) or hex address (kind 10)
//   data         hex data field
//   reg_cnt      saturating count of kind-01 records
//   mem_cnt      saturating count of kind-10 records
module cpu_trace_extractor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [1:0]       format_type,
    output logic             valid,
    output logic [1:0]       kind,
    output logic [15:0]      time_val,
    output logic [31:0]      pc,
    output logic [31:0]      dest,
    output logic [31:0]      data,
    output logic [CNT_W-1:0] reg_cnt,
    output logic [CNT_W-1:0] mem_cnt
);

    localparam logic [7:0] C_CARET = 8'h5E;  // '^'
    localparam logic [7:0] C_AT    = 8'h40;  // '@'
    localparam logic [7:0] C_COLON = 8'h3A;  // ':'
    localparam logic [7:0] C_SPACE = 8'h20;  // ' '
    localparam logic [7:0] C_DOLR  = 8'h24;  // '$'
    localparam logic [7:0] C_STAR  = 8'h2A;  // '*'
    localparam logic [7:0] C_LT    = 8'h3C;  // '<'
    localparam logic [7:0] C_EQ    = 8'h3D;  // '='

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_TIME,
        S_PC,
        S_SEP,
        S_REG,
        S_ADDR,
        S_ARROW,
        S_EQ,
        S_DSP,
        S_DATA
    } state_t;

    state_t      state, nxt_state;
    logic [15:0] s_time, n_time;
    logic [31:0] s_pc, n_pc;
    logic [31:0] s_dest, n_dest;
    logic [31:0] s_data, n_data;

    // Character classification; hex digits are lowercase only.
    logic       is_dec;
    logic       is_hex;
    logic [3:0] nib;
    logic       commit_reg;
    logic       commit_mem;

    assign is_dec = (char >= 8'h30) && (char <= 8'h39);
    assign is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
    // 'a'..'f' have low nibble 1..6, so +9 maps them onto 10..15.
    assign nib    = is_dec ? char[3:0] : (char[3:0] + 4'd9);

    // format_type 11 is not a legal verdict and must not commit.
    assign commit_reg = (format_type == 2'b01);
    assign commit_mem = (format_type == 2'b10);

    always_comb begin
        nxt_state = state;
        n_time    = s_time;
        n_pc      = s_pc;
        n_dest    = s_dest;
        n_data    = s_data;
        if (char == C_CARET) begin
            // Start of line wins in every state, including mid-field.
            nxt_state = S_TIME;
            n_time    = 16'd0;
            n_pc      = 32'd0;
            n_dest    = 32'd0;
            n_data    = 32'd0;
        end else begin
            case (state)
                S_IDLE: nxt_state = S_IDLE;
                S_TIME: begin
                    if (is_dec)             n_time    = s_time * 16'd10 + {12'd0, char[3:0]};
                    else if (char == C_AT)  nxt_state = S_PC;
                    else                    nxt_state = S_IDLE;
                end
                S_PC: begin
                    if (is_hex)               n_pc      = {s_pc[27:0], nib};
                    else if (char == C_COLON) nxt_state = S_SEP;
                    else                      nxt_state = S_IDLE;
                end
                S_SEP: begin
                    if (char == C_SPACE)     nxt_state = S_SEP;
                    else if (char == C_DOLR) nxt_state = S_REG;
                    else if (char == C_STAR) nxt_state = S_ADDR;
                    else                     nxt_state = S_IDLE;
                end
                S_REG: begin
                    if (is_dec)               n_dest    = s_dest * 32'd10 + {28'd0, char[3:0]};
                    else if (char == C_SPACE) nxt_state = S_ARROW;
                    else if (char == C_LT)    nxt_state = S_EQ;
                    else                      nxt_state = S_IDLE;
                end
                S_ADDR: begin
                    if (is_hex)               n_dest    = {s_dest[27:0], nib};
                    else if (char == C_SPACE) nxt_state = S_ARROW;
                    else if (char == C_LT)    nxt_state = S_EQ;
                    else                      nxt_state = S_IDLE;
                end
                S_ARROW: begin
                    if (char == C_SPACE)   nxt_state = S_ARROW;
                    else if (char == C_LT) nxt_state = S_EQ;
                    else                   nxt_state = S_IDLE;
                end
                S_EQ: begin
                    if (char == C_EQ) nxt_state = S_DSP;
                    else              nxt_state = S_IDLE;
                end
                S_DSP: begin
                    if (char == C_SPACE) begin
                        nxt_state = S_DSP;
                    end else if (is_hex) begin
                        n_data    = {28'd0, nib};
                        nxt_state = S_DATA;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
                S_DATA: begin
                    // '#' and any other non-hex char both end the line;
                    // the shadow is kept for the commit one cycle later.
                    if (is_hex) n_data    = {s_data[27:0], nib};
                    else        nxt_state = S_IDLE;
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            s_time   <= 16'd0;
            s_pc     <= 32'd0;
            s_dest   <= 32'd0;
            s_data   <= 32'd0;
            valid    <= 1'b0;
            kind     <= 2'b00;
            time_val <= 16'd0;
            pc       <= 32'd0;
            dest     <= 32'd0;
            data     <= 32'd0;
            reg_cnt  <= '0;
            mem_cnt  <= '0;
        end else begin
            state  <= nxt_state;
            s_time <= n_time;
            s_pc   <= n_pc;
            s_dest <= n_dest;
            s_data <= n_data;
            valid  <= 1'b0;
            // Commit reads the pre-edge shadow, so a '^' right after '#'
            // cannot corrupt the record being committed.
            if (commit_reg || commit_mem) begin
                valid    <= 1'b1;
                kind     <= format_type;
                time_val <= s_time;
                pc       <= s_pc;
                dest     <= s_dest;
                data     <= s_data;
            end
            if (commit_reg && (reg_cnt != CNT_MAX)) reg_cnt <= reg_cnt + CNT_ONE;
            if (commit_mem && (mem_cnt != CNT_MAX)) mem_cnt <= mem_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cpu_trace_extractor.sv
// Purpose : directed trace lines against a string-level record model, checked
//           every cycle, plus literal expectations on the captured records.
// Latency : model commits one edge after the '#' edge, like cpu_checker.
// Backpressure: none; one char per clock.
module tb_cpu_trace_extractor;

    localparam int CNT_W = 2;  // small so saturation is reachable

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       char_i;
    logic [1:0]       ft;
    logic             valid;
    logic [1:0]       kind;
    logic [15:0]      time_val;
    logic [31:0]      pc, dest, data;
    logic [CNT_W-1:0] reg_cnt, mem_cnt;

    always #5 clk = ~clk;

    cpu_trace_extractor #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char_i),
        .format_type (ft),
        .valid       (valid),
        .kind        (kind),
        .time_val    (time_val),
        .pc          (pc),
        .dest        (dest),
        .data        (data),
        .reg_cnt     (reg_cnt),
        .mem_cnt     (mem_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- record model ----------------
    function automatic int hexv(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        return int'(c) - 97 + 10;
    endfunction

    // Reads the fields of a well-formed line straight from its text.
    function automatic void parse_line(input string s, output logic [15:0] t,
                                       output logic [31:0] p, output logic [31:0] d,
                                       output logic [31:0] dt);
        int i;
        bit is_reg;
        i = 0;
        for (int j = 0; j < s.len(); j++) if (s[j] == "^") i = j;
        i++;
        t = 0; p = 0; d = 0; dt = 0;
        while (s[i] != "@") begin t = t * 16'd10 + 16'(hexv(s[i])); i++; end
        i++;
        while (s[i] != ":") begin p = p * 32'd16 + 32'(hexv(s[i])); i++; end
        i++;
        while (s[i] == " ") i++;
        is_reg = (s[i] == "$");
        i++;
        while (s[i] != " " && s[i] != "<") begin
            d = is_reg ? d * 32'd10 + 32'(hexv(s[i])) : d * 32'd16 + 32'(hexv(s[i]));
            i++;
        end
        while (s[i] != "=") i++;
        i++;
        while (s[i] == " ") i++;
        while (s[i] != "#") begin dt = dt * 32'd16 + 32'(hexv(s[i])); i++; end
    endfunction

    logic [15:0] m_time, pend_time;
    logic [31:0] m_pc, m_dest, m_data, pend_pc, pend_dest, pend_data;
    logic [1:0]  pend_ft;

    logic             exp_valid;
    logic [1:0]       exp_kind;
    logic [15:0]      exp_time;
    logic [31:0]      exp_pc, exp_dest, exp_data;
    logic [CNT_W-1:0] exp_reg, exp_mem;

    always @(posedge clk) begin
        if (!reset) begin
            exp_valid <= 0; exp_kind <= 0; exp_time <= 0; exp_pc <= 0;
            exp_dest  <= 0; exp_data <= 0; exp_reg  <= 0; exp_mem <= 0;
        end else begin
            exp_valid <= (ft == 2'd1) || (ft == 2'd2);
            if (ft == 2'd1 || ft == 2'd2) begin
                exp_kind <= ft; exp_time <= m_time; exp_pc <= m_pc;
                exp_dest <= m_dest; exp_data <= m_data;
            end
            if (ft == 2'd1 && exp_reg != {CNT_W{1'b1}}) exp_reg <= exp_reg + 1'b1;
            if (ft == 2'd2 && exp_mem != {CNT_W{1'b1}}) exp_mem <= exp_mem + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("valid",   32'(valid),    32'(exp_valid));
            cmp("kind",    32'(kind),     32'(exp_kind));
            cmp("time",    32'(time_val), 32'(exp_time));
            cmp("pc",      pc,            exp_pc);
            cmp("dest",    dest,          exp_dest);
            cmp("data",    data,          exp_data);
            cmp("reg_cnt", 32'(reg_cnt),  32'(exp_reg));
            cmp("mem_cnt", 32'(mem_cnt),  32'(exp_mem));
        end
    end

    typedef struct {
        logic [1:0]       k;
        logic [15:0]      t;
        logic [31:0]      p, d, dt;
        logic [CNT_W-1:0] rc, mc;
    } rec_t;
    rec_t caps[$];

    always @(negedge clk) begin
        if (valid === 1'b1) caps.push_back('{kind, time_val, pc, dest, data, reg_cnt, mem_cnt});
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] c, input logic rst);
        @(posedge clk);
        #1;
        char_i = c; reset = rst; ft = pend_ft;
        m_time = pend_time; m_pc = pend_pc; m_dest = pend_dest; m_data = pend_data;
        pend_ft = 2'd0;
    endtask

    task automatic send_line(input string s, input logic [1:0] f, input int rst_at);
        for (int i = 0; i < s.len(); i++) drive(8'(s[i]), (i == rst_at) ? 1'b0 : 1'b1);
        if (f != 2'd0) parse_line(s, pend_time, pend_pc, pend_dest, pend_data);
        pend_ft = f;
    endtask

    // Hand-computed records, in commit order.
    localparam int NREC = 6;
    logic [1:0]       lk  [NREC] = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [15:0]      lt  [NREC] = '{16'd10, 16'd4, 16'd20, 16'd7, 16'd12, 16'd9};
    logic [31:0]      lp  [NREC] = '{32'h00003010, 32'hffffffff, 32'h00003020,
                                     32'h00003014, 32'h00003000, 32'h00000100};
    logic [31:0]      ld  [NREC] = '{32'd1, 32'h0000000c, 32'd5, 32'd31, 32'd2, 32'd7};
    logic [31:0]      ldt [NREC] = '{32'h0000000a, 32'hdeadbeef, 32'h00000002,
                                     32'h00000001, 32'h00000005, 32'h12345678};
    logic [CNT_W-1:0] lrc [NREC] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
    logic [CNT_W-1:0] lmc [NREC] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};

    localparam logic [7:0] NL = 8'h0a;

    initial begin
        reset = 1'b0; char_i = NL; ft = 2'd0; pend_ft = 2'd0;
        pend_time = 0; pend_pc = 0; pend_dest = 0; pend_data = 0;
        m_time = 0; m_pc = 0; m_dest = 0; m_data = 0;

        drive(NL, 1'b0);
        chk_en = 1'b1;
        drive(NL, 1'b0);
        @(negedge clk);
        cmp("reset_valid", 32'(valid), 32'd0);
        cmp("reset_data",  data,       32'd0);
        cmp("reset_reg",   32'(reg_cnt), 32'd0);

        drive(NL, 1'b1);
        send_line("^10@00003010: $1 <= 0000000a#", 2'd1, -1);
        drive(NL, 1'b1);
        send_line("^4@ffffffff: *0000000c <=deadbeef#", 2'd2, -1);
        drive(NL, 1'b1);
        // back-to-back: second '^' directly after first '#'
        send_line("^20@00003020: $5 <= 00000002#", 2'd1, -1);
        send_line("^7@00003014: $31 <= 00000001#", 2'd1, -1);
        drive(NL, 1'b1);
        // short pc: cpu_checker rejects, nothing commits
        send_line("^10@3010: $1 <= 0000000a#", 2'd0, -1);
        drive(NL, 1'b1);
        drive(NL, 1'b1);
        @(negedge clk);
        cmp("malformed_data", data, 32'h00000001);
        cmp("malformed_reg",  32'(reg_cnt), 32'd3);
        // illegal verdict 11 must not commit
        pend_ft = 2'd3;
        drive(NL, 1'b1);
        drive(NL, 1'b1);
        @(negedge clk);
        cmp("ft11_valid", 32'(valid), 32'd0);
        send_line("^^12@00003000: $2<=00000005#", 2'd1, -1);
        drive(NL, 1'b1);
        // reset pulse in the middle of the pc field
        send_line("^55@0000abcd: $3 <= 00000009#", 2'd0, 6);
        @(negedge clk);
        cmp("midreset_data", data, 32'd0);
        cmp("midreset_kind", 32'(kind), 32'd0);
        cmp("midreset_reg",  32'(reg_cnt), 32'd0);
        drive(NL, 1'b1);
        send_line("^9@00000100: $7 <= 12345678#", 2'd1, -1);
        drive(NL, 1'b1);
        drive(NL, 1'b1);
        drive(NL, 1'b1);
        @(negedge clk);
        chk_en = 1'b0;

        cmp("record_count", 32'(caps.size()), 32'(NREC));
        for (int i = 0; i < NREC && i < caps.size(); i++) begin
            cmp($sformatf("rec%0d_kind", i), 32'(caps[i].k),  32'(lk[i]));
            cmp($sformatf("rec%0d_time", i), 32'(caps[i].t),  32'(lt[i]));
            cmp($sformatf("rec%0d_pc", i),   caps[i].p,       lp[i]);
            cmp($sformatf("rec%0d_dest", i), caps[i].d,       ld[i]);
            cmp($sformatf("rec%0d_data", i), caps[i].dt,      ldt[i]);
            cmp($sformatf("rec%0d_reg", i),  32'(caps[i].rc), 32'(lrc[i]));
            cmp($sformatf("rec%0d_mem", i),  32'(caps[i].mc), 32'(lmc[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
